// File: rtl/riscv_test_pkg.sv
// Shared definitions for the RISC-V end-of-test monitor: state encoding and
// default tohost address / pass value.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0064;
    localparam logic [31:0] DEFAULT_PASS_VALUE  = 32'd25;

endpackage

// File: rtl/riscv_test_monitor_store_trace_ring.sv
// Ring buffer of the most recent stores with a combinational indexed read
// (index 0 = newest entry).
module store_trace_ring #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 4,
    localparam int IDX_W      = $clog2(TRACE_DEPTH),
    localparam int CNT_W      = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]  trace_cnt,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [ADDR_W-1:0] addr_mem_r [TRACE_DEPTH];
    logic [DATA_W-1:0] data_mem_r [TRACE_DEPTH];
    logic [IDX_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  rd_ptr_s;

    // Write path: store entry, advance pointer, saturate occupancy at depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                addr_mem_r[i] <= '0;
                data_mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            addr_mem_r[wr_ptr_r] <= wr_addr;
            data_mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r             <= wr_ptr_r + IDX_W'(1);
            if (cnt_r != CNT_W'(TRACE_DEPTH)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Read path: pointer arithmetic wraps naturally since depth is a power of 2.
    always_comb begin
        rd_ptr_s = wr_ptr_r - IDX_W'(1) - rd_idx;
        rd_valid = ({1'b0, rd_idx} < cnt_r);
        if (rd_valid) begin
            rd_addr = addr_mem_r[rd_ptr_s];
            rd_data = data_mem_r[rd_ptr_s];
        end else begin
            rd_addr = '0;
            rd_data = '0;
        end
    end

    assign trace_cnt = cnt_r;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor snooping the core data port: PASS/FAIL via tohost store,
// TIMEOUT otherwise, plus a store trace. TESTMON_SIM_FINISH_EN adds a sim-only $finish.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
    parameter logic [DATA_W-1:0] PASS_VALUE     = DATA_W'(DEFAULT_PASS_VALUE),
    parameter int                TIMEOUT_CYCLES = 20,
    parameter int                CNT_W          = 16,
    parameter int                TRACE_DEPTH    = 4,
    localparam int               IDX_W          = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic [IDX_W-1:0]  trace_idx,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] fail_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [IDX_W:0]    trace_cnt,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_r, state_nx_s;
    logic              running_s, tohost_hit_s, timeout_hit_s;
    logic              done_r, pass_r, fail_r, timeout_r;
    logic [DATA_W-1:0] fail_code_r;
    logic [CNT_W-1:0]  cycle_cnt_r, store_cnt_r;

    assign running_s     = (state_r == ST_RUN);
    assign tohost_hit_s  = memwrite && (address == TOHOST_ADDR);
    assign timeout_hit_s = (cycle_cnt_r == TIMEOUT_CNT);

    // Next-state: a tohost store outranks a coincident timeout; verdicts are sticky.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (tohost_hit_s) begin
                    if (write_data == PASS_VALUE) begin
                        state_nx_s = ST_PASS;
                    end else begin
                        state_nx_s = ST_FAIL;
                    end
                end else if (timeout_hit_s) begin
                    state_nx_s = ST_TIMEOUT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: state_nx_s = state_r;
            default:                      state_nx_s = ST_RUN;
        endcase
    end

    // State register and registered verdict flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            timeout_r   <= 1'b0;
            fail_code_r <= '0;
        end else begin
            state_r   <= state_nx_s;
            done_r    <= (state_nx_s != ST_RUN);
            pass_r    <= (state_nx_s == ST_PASS);
            fail_r    <= (state_nx_s == ST_FAIL);
            timeout_r <= (state_nx_s == ST_TIMEOUT);
            if (running_s && tohost_hit_s && (write_data != PASS_VALUE)) begin
                fail_code_r <= write_data;
            end
        end
    end

    // Saturating cycle/store counters, frozen once a verdict is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_r <= '0;
            store_cnt_r <= '0;
        end else if (running_s) begin
            if (cycle_cnt_r != CNT_MAX) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            end
            if (memwrite && (store_cnt_r != CNT_MAX)) begin
                store_cnt_r <= store_cnt_r + CNT_W'(1);
            end
        end
    end

    store_trace_ring #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (memwrite && running_s),
        .wr_addr   (address),
        .wr_data   (write_data),
        .rd_idx    (trace_idx),
        .trace_cnt (trace_cnt),
        .rd_valid  (trace_valid),
        .rd_addr   (trace_addr),
        .rd_data   (trace_data)
    );

    assign done      = done_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign timeout   = timeout_r;
    assign fail_code = fail_code_r;
    assign cycle_cnt = cycle_cnt_r;
    assign store_cnt = store_cnt_r;

`ifdef TESTMON_SIM_FINISH_EN
    logic done_q_r;

    // Delayed done, so the report fires once in the cycle done rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q_r <= 1'b0;
        end else begin
            done_q_r <= done_r;
        end
    end

    // Simulation-only end-of-test report.
    always @(negedge clk) begin
        if (done_r && !done_q_r) begin
            $display("testmon: verdict=%s cycles=%0d stores=%0d fail_code=0x%0h",
                     pass_r ? "PASS" : (fail_r ? "FAIL" : "TIMEOUT"),
                     cycle_cnt_r, store_cnt_r, fail_code_r);
            $finish;
        end
    end
`endif

endmodule
